// File: rtl/tcp_buf_ptr_responder.sv
// Responder for the TCP app buffer-pointer protocol: answers MSG_REQ with a grant
// from a per-flow ring, applies ADJUST_IDX consumer updates, and absorbs producer adds.
module tcp_buf_ptr_responder #(
  parameter int unsigned FLOWID_W       = 3,
  parameter int unsigned BUF_BYTES_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned PTR_W          = 32,
  parameter int unsigned IDX_W          = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_val,
  output logic                req_rdy,
  input  logic                req_type,
  input  logic [FLOWID_W-1:0] req_flowid,
  input  logic [PTR_W:0]      req_length,
  input  logic [IDX_W:0]      req_old_idx,
  input  logic [PTR_W:0]      req_old_len,
  input  logic [PTR_W:0]      req_bytes_consumed,
  output logic                resp_val,
  input  logic                resp_rdy,
  output logic [FLOWID_W-1:0] resp_flowid,
  output logic [PTR_W-1:0]    resp_bufptr,
  output logic [IDX_W:0]      resp_idx,
  output logic [PTR_W:0]      resp_len,
  output logic [PTR_W:0]      resp_cap,
  input  logic                prod_val,
  input  logic [FLOWID_W-1:0] prod_flowid,
  input  logic [PTR_W:0]      prod_bytes,
  output logic                overflow,
  output logic [15:0]         stale_cnt
);

  localparam int unsigned NUM_FLOWS = 1 << FLOWID_W;
  localparam logic [PTR_W:0] CAP =
    {{(PTR_W - BUF_BYTES_LOG2){1'b0}}, 1'b1, {BUF_BYTES_LOG2{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP, S_UPDATE} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_live;

  logic [PTR_W:0] r_head [NUM_FLOWS];
  logic [PTR_W:0] r_tail [NUM_FLOWS];
  logic [IDX_W:0] r_idx  [NUM_FLOWS];

  logic                r_type;
  logic [FLOWID_W-1:0] r_flowid;
  logic [PTR_W:0]      r_length;
  logic [IDX_W:0]      r_old_idx;
  logic [PTR_W:0]      r_old_len;
  logic [PTR_W:0]      r_consumed;

  logic [FLOWID_W-1:0] r_resp_flowid;
  logic [PTR_W-1:0]    r_resp_bufptr;
  logic [IDX_W:0]      r_resp_idx;
  logic [PTR_W:0]      r_resp_len;
  logic [PTR_W:0]      r_resp_cap;
  logic                r_overflow;
  logic [15:0]         r_stale;

  logic [PTR_W:0]   w_head, w_tail, w_avail, w_off, w_contig, w_len_a, w_len;
  logic [IDX_W:0]   w_idx;
  logic [PTR_W-1:0] w_bufptr;
  logic             w_upd_ok;
  logic [PTR_W:0]   w_p_avail;
  logic [PTR_W+1:0] w_p_sum;
  logic             w_p_ok;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (req_val && req_rdy) w_state_nxt = S_LOOKUP;
      S_LOOKUP: w_state_nxt = r_type ? S_UPDATE : S_RESP;
      S_RESP:   if (resp_rdy) w_state_nxt = S_IDLE;
      S_UPDATE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs; r_live keeps req_rdy low while reset is held
  always_comb begin
    req_rdy  = r_live && (r_state == S_IDLE);
    resp_val = (r_state == S_RESP);
  end

  always_comb begin
    w_head    = r_head[r_flowid];
    w_tail    = r_tail[r_flowid];
    w_idx     = r_idx[r_flowid];
    w_avail   = w_tail - w_head;
    w_off     = (PTR_W + 1)'(w_head[BUF_BYTES_LOG2-1:0]);
    w_contig  = CAP - w_off;
    w_len_a   = (r_length < w_avail) ? r_length : w_avail;
    w_len     = (w_len_a < w_contig) ? w_len_a : w_contig;
    w_bufptr  = PTR_W'(BASE_ADDR) + (PTR_W'(r_flowid) << BUF_BYTES_LOG2) + w_off[PTR_W-1:0];
    w_upd_ok  = (r_old_idx == w_idx) && (r_consumed <= w_avail);
    // Producer check uses the pre-update head and one extra bit against sum wrap
    w_p_avail = r_tail[prod_flowid] - r_head[prod_flowid];
    w_p_sum   = {1'b0, w_p_avail} + {1'b0, prod_bytes};
    w_p_ok    = (w_p_sum <= {1'b0, CAP});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type     <= 1'b0;
      r_flowid   <= '0;
      r_length   <= '0;
      r_old_idx  <= '0;
      r_old_len  <= '0;
      r_consumed <= '0;
    end else if (req_val && req_rdy) begin
      r_type     <= req_type;
      r_flowid   <= req_flowid;
      r_length   <= req_length;
      r_old_idx  <= req_old_idx;
      r_old_len  <= req_old_len;
      r_consumed <= req_bytes_consumed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_flowid <= '0;
      r_resp_bufptr <= '0;
      r_resp_idx    <= '0;
      r_resp_len    <= '0;
      r_resp_cap    <= '0;
    end else if (r_state == S_LOOKUP && !r_type) begin
      r_resp_flowid <= r_flowid;
      r_resp_bufptr <= w_bufptr;
      r_resp_idx    <= w_idx;
      r_resp_len    <= w_len;
      r_resp_cap    <= CAP;
    end
  end

  // Tail (producer) and head/idx (UPDATE) are disjoint fields, so both may land in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '{default: '0};
      r_tail     <= '{default: '0};
      r_idx      <= '{default: '0};
      r_overflow <= 1'b0;
      r_stale    <= '0;
    end else begin
      r_overflow <= prod_val && !w_p_ok;
      if (prod_val && w_p_ok)
        r_tail[prod_flowid] <= r_tail[prod_flowid] + prod_bytes;
      if (r_state == S_UPDATE) begin
        if (w_upd_ok) begin
          r_head[r_flowid] <= w_head + r_consumed;
          if (r_consumed == r_old_len)
            r_idx[r_flowid] <= w_idx + 1'b1;
        end else if (r_stale != '1) begin
          r_stale <= r_stale + 16'd1;
        end
      end
    end
  end

  assign resp_flowid = r_resp_flowid;
  assign resp_bufptr = r_resp_bufptr;
  assign resp_idx    = r_resp_idx;
  assign resp_len    = r_resp_len;
  assign resp_cap    = r_resp_cap;
  assign overflow    = r_overflow;
  assign stale_cnt   = r_stale;

endmodule

// File: tb/tb_tcp_buf_ptr_responder.sv
// Scoreboard bench for tcp_buf_ptr_responder: directed requests push expected
// responses; a negedge monitor pops and compares on each response handshake.
module tb_tcp_buf_ptr_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_val = 1'b0;
  logic        req_rdy;
  logic        req_type = 1'b0;
  logic [2:0]  req_flowid = '0;
  logic [32:0] req_length = '0;
  logic [8:0]  req_old_idx = '0;
  logic [32:0] req_old_len = '0;
  logic [32:0] req_bytes_consumed = '0;
  logic        resp_val;
  logic        resp_rdy = 1'b1;
  logic [2:0]  resp_flowid;
  logic [31:0] resp_bufptr;
  logic [8:0]  resp_idx;
  logic [32:0] resp_len;
  logic [32:0] resp_cap;
  logic        prod_val = 1'b0;
  logic [2:0]  prod_flowid = '0;
  logic [32:0] prod_bytes = '0;
  logic        overflow;
  logic [15:0] stale_cnt;

  tcp_buf_ptr_responder #(
    .FLOWID_W(3), .BUF_BYTES_LOG2(12), .BASE_ADDR(32'h0), .PTR_W(32), .IDX_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val), .req_rdy(req_rdy), .req_type(req_type), .req_flowid(req_flowid),
    .req_length(req_length), .req_old_idx(req_old_idx), .req_old_len(req_old_len),
    .req_bytes_consumed(req_bytes_consumed),
    .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_flowid(resp_flowid),
    .resp_bufptr(resp_bufptr), .resp_idx(resp_idx), .resp_len(resp_len), .resp_cap(resp_cap),
    .prod_val(prod_val), .prod_flowid(prod_flowid), .prod_bytes(prod_bytes),
    .overflow(overflow), .stale_cnt(stale_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  f;
    logic [31:0] ptr;
    logic [8:0]  idx;
    logic [32:0] len;
  } exp_t;

  exp_t q[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && resp_val && resp_rdy) begin
      if (q.size() == 0) begin
        chk("unexpected_resp", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_flowid", resp_flowid, e.f);
        chk("resp_bufptr", resp_bufptr, e.ptr);
        chk("resp_idx", resp_idx, e.idx);
        chk("resp_len", resp_len, e.len);
        chk("resp_cap", resp_cap, 33'd4096);
      end
    end
  end

  task automatic wait_idle(input string nm);
    int unsigned n = 0;
    while (!req_rdy && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_rdy) chk(nm, 0, 1);
  endtask

  task automatic do_req(input logic typ, input logic [2:0] f, input logic [32:0] len,
                        input logic [8:0] oidx, input logic [32:0] olen, input logic [32:0] cons,
                        input logic check_lat, input logic wait_done);
    @(posedge clk); #1;
    wait_idle("req_rdy_timeout");
    req_type = typ; req_flowid = f; req_length = len;
    req_old_idx = oidx; req_old_len = olen; req_bytes_consumed = cons;
    req_val = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0;
    if (check_lat) begin
      chk("lat_cyc1_resp_val", resp_val, 0);
      @(posedge clk); #1;
      chk("lat_cyc2_resp_val", resp_val, 1);
    end
    if (wait_done) wait_idle("done_timeout");
  endtask

  task automatic msg(input logic [2:0] f, input logic [32:0] len,
                     input logic [31:0] eptr, input logic [8:0] eidx, input logic [32:0] elen);
    exp_t e;
    e.f = f; e.ptr = eptr; e.idx = eidx; e.len = elen;
    q.push_back(e);
    do_req(1'b0, f, len, '0, '0, '0, 1'b1, 1'b1);
  endtask

  task automatic adj(input logic [2:0] f, input logic [8:0] oidx, input logic [32:0] olen,
                     input logic [32:0] cons);
    do_req(1'b1, f, '0, oidx, olen, cons, 1'b0, 1'b1);
  endtask

  task automatic prod(input logic [2:0] f, input logic [32:0] b, input logic exp_ovf);
    @(posedge clk); #1;
    prod_val = 1'b1; prod_flowid = f; prod_bytes = b;
    @(posedge clk); #1;
    prod_val = 1'b0;
    chk("overflow_pulse", overflow, exp_ovf);
    @(posedge clk); #1;
    chk("overflow_clear", overflow, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_resp_val", resp_val, 0);
    chk("rst_resp_len", resp_len, 0);
    chk("rst_resp_bufptr", resp_bufptr, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_stale_cnt", stale_cnt, 0);
    #4 rst_n = 1'b1;

    prod(3'd2, 33'd100, 1'b0);
    msg(3'd2, 33'd64, 32'h2000, 9'd0, 33'd64);
    adj(3'd2, 9'd0, 33'd64, 33'd64);
    msg(3'd2, 33'd200, 32'h2040, 9'd1, 33'd36);

    // Ring-end clamp on flow 0
    prod(3'd0, 33'd4000, 1'b0);
    adj(3'd0, 9'd0, 33'd4000, 33'd4000);
    prod(3'd0, 33'd200, 1'b0);
    msg(3'd0, 33'd500, 32'h0FA0, 9'd1, 33'd96);

    adj(3'd2, 9'd5, 33'd36, 33'd10);
    chk("stale_idx", stale_cnt, 1);
    msg(3'd2, 33'd200, 32'h2040, 9'd1, 33'd36);
    adj(3'd2, 9'd1, 33'd50, 33'd50);
    chk("stale_consumed_gt_avail", stale_cnt, 2);
    adj(3'd2, 9'd1, 33'd36, 33'd10);
    chk("partial_adj_stale", stale_cnt, 2);
    msg(3'd2, 33'd100, 32'h204A, 9'd1, 33'd26);

    prod(3'd3, 33'd4096, 1'b0);
    prod(3'd3, 33'd1, 1'b1);
    msg(3'd3, 33'd8, 32'h3000, 9'd0, 33'd8);
    adj(3'd3, 9'd0, 33'd4096, 33'd4096);
    msg(3'd3, 33'd8, 32'h3000, 9'd1, 33'd0);
    msg(3'd5, 33'd10, 32'h5000, 9'd0, 33'd0);

    // Backpressure: response must hold while resp_rdy is low
    prod(3'd3, 33'd16, 1'b0);
    resp_rdy = 1'b0;
    begin
      exp_t e;
      e.f = 3'd3; e.ptr = 32'h3000; e.idx = 9'd1; e.len = 33'd16;
      q.push_back(e);
    end
    do_req(1'b0, 3'd3, 33'd16, '0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_resp_val", resp_val, 1);
      chk("hold_req_rdy", req_rdy, 0);
      chk("hold_bufptr", resp_bufptr, 32'h3000);
      chk("hold_len", resp_len, 33'd16);
    end
    resp_rdy = 1'b1;
    wait_idle("hold_release_timeout");

    // Reset in the middle of a pending response
    resp_rdy = 1'b0;
    do_req(1'b0, 3'd3, 33'd4, '0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_resp_val", resp_val, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_resp_val", resp_val, 0);
    chk("midrst_resp_len", resp_len, 0);
    chk("midrst_req_rdy", req_rdy, 0);
    chk("midrst_stale_cnt", stale_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    resp_rdy = 1'b1;
    msg(3'd3, 33'd8, 32'h3000, 9'd0, 33'd0);
    msg(3'd2, 33'd200, 32'h2000, 9'd0, 33'd0);
    msg(3'd0, 33'd500, 32'h0000, 9'd0, 33'd0);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
